// File: rtl/passwd_checker.sv
// passwd_checker: collects six keypad digits, compares them with q1..q6, and drives unlock/fail/alarm with timed lockout.
// Optional backspace key (4'hA) is built only when PASSWD_CHECKER_BACKSPACE_EN is defined.
module passwd_checker #(
  parameter int MAX_TRIES   = 3,
  parameter int OPEN_CYCLES = 16,
  parameter int LOCK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [3:0] q1,
  input  logic [3:0] q2,
  input  logic [3:0] q3,
  input  logic [3:0] q4,
  input  logic [3:0] q5,
  input  logic [3:0] q6,
  output logic       unlock,
  output logic       fail,
  output logic       alarm,
  output logic [2:0] entry_cnt,
  output logic [1:0] err_cnt
);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_FAIL,
    S_LOCKOUT
  } state_e;

  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    MAX_ERR    = 2'(MAX_TRIES);
  localparam logic [3:0]    KEY_ENTER  = 4'hB;
  localparam logic [3:0]    KEY_CANCEL = 4'hC;
`ifdef PASSWD_CHECKER_BACKSPACE_EN
  localparam logic [3:0]    KEY_BACK   = 4'hA;
`endif

  state_e        state_q, state_d;
  logic [3:0]    dig_q [6];
  logic [3:0]    dig_d [6];
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    err_q, err_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          unlock_q, fail_q, alarm_q;

  logic          match;
  logic [1:0]    err_inc;
  state_e        wrong_state;
  logic          clear_buf;

  assign match = (dig_q[0] == q1) && (dig_q[1] == q2) && (dig_q[2] == q3) &&
                 (dig_q[3] == q4) && (dig_q[4] == q5) && (dig_q[5] == q6);

  assign err_inc     = (err_q < MAX_ERR) ? err_q + 2'd1 : err_q;
  assign wrong_state = (err_inc == MAX_ERR) ? S_LOCKOUT : S_FAIL;

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    dig_d     = dig_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    tmr_d     = tmr_q;
    clear_buf = 1'b0;

    case (state_q)
      S_ENTRY: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (cnt_q < 3'd6) begin
              for (int i = 0; i < 6; i++) begin
                if (cnt_q == 3'(i)) dig_d[i] = key_code;
              end
              cnt_d = cnt_q + 3'd1;
            end
          end else if (key_code == KEY_CANCEL) begin
            clear_buf = 1'b1;
          end else if (key_code == KEY_ENTER) begin
            if (cnt_q == 3'd6) begin
              state_d = S_CHECK;
            end else begin
              // A short entry is a wrong attempt that skips the compare cycle.
              err_d     = err_inc;
              state_d   = wrong_state;
              tmr_d     = LOCK_LOAD;
              clear_buf = 1'b1;
            end
`ifdef PASSWD_CHECKER_BACKSPACE_EN
          end else if (key_code == KEY_BACK) begin
            if (cnt_q != 3'd0) begin
              for (int i = 0; i < 6; i++) begin
                if ((cnt_q - 3'd1) == 3'(i)) dig_d[i] = 4'd0;
              end
              cnt_d = cnt_q - 3'd1;
            end
`endif
          end
        end
      end

      S_CHECK: begin
        clear_buf = 1'b1;
        if (match) begin
          err_d   = 2'd0;
          state_d = S_OPEN;
          tmr_d   = OPEN_LOAD;
        end else begin
          err_d   = err_inc;
          state_d = wrong_state;
          tmr_d   = LOCK_LOAD;
        end
      end

      S_OPEN: begin
        if (tmr_q == '0) state_d = S_ENTRY;
        else             tmr_d   = tmr_q - 1'b1;
      end

      S_FAIL: state_d = S_ENTRY;

      S_LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d   = S_ENTRY;
          err_d     = 2'd0;
          clear_buf = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      default: state_d = S_ENTRY;
    endcase

    if (clear_buf) begin
      for (int i = 0; i < 6; i++) dig_d[i] = 4'd0;
      cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_ENTRY;
      // NOTE: the digit buffer is just six small registers, so it is reset with the control state.
      for (int i = 0; i < 6; i++) dig_q[i] <= 4'd0;
      cnt_q    <= 3'd0;
      err_q    <= 2'd0;
      tmr_q    <= '0;
      unlock_q <= 1'b0;
      fail_q   <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dig_q    <= dig_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      tmr_q    <= tmr_d;
      // NOTE: outputs are registered decodes of the next state, so they align with the state register.
      unlock_q <= (state_d == S_OPEN);
      alarm_q  <= (state_d == S_LOCKOUT);
      fail_q   <= (state_d == S_FAIL) ||
                  ((state_d == S_LOCKOUT) && (state_q != S_LOCKOUT));
    end
  end

  assign unlock    = unlock_q;
  assign fail      = fail_q;
  assign alarm     = alarm_q;
  assign entry_cnt = cnt_q;
  assign err_cnt   = err_q;

endmodule
